// File: rtl/pair_tree_eval_pipe_pkg.sv
// Shared types and helpers for the pair-term XOR reduction pipeline:
// pair function encoding, the per-pair function and the stage-count rule.
package pair_tree_pkg;

   typedef enum logic [1:0] {
      PAIR_ANDN = 2'd0,
      PAIR_ORN  = 2'd1,
      PAIR_XOR  = 2'd2,
      PAIR_XNOR = 2'd3
   } pair_op_e;

   function automatic logic pair_term(input pair_op_e op, input logic a, input logic b);
      logic t;
      t = 1'b0;
      case (op)
         PAIR_ANDN: t = a & ~b;
         PAIR_ORN:  t = a | ~b;
         PAIR_XOR:  t = a ^ b;
         PAIR_XNOR: t = ~(a ^ b);
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

   // One capture stage plus ceil(log2(num_pairs)/lvl_per_stg) reduction stages.
   function automatic int stage_count(input int num_pairs, input int lvl_per_stg);
      return 1 + ($clog2(num_pairs) + lvl_per_stg - 1) / lvl_per_stg;
   endfunction

endpackage

// File: rtl/pair_tree_eval_pipe_if.sv
// Handshake bundle for pair_tree_eval_pipe: input side, output side and status.
interface pair_tree_eval_pipe_if
   import pair_tree_pkg::*;
#(
   parameter int NUM_PAIRS = 8,
   parameter int TAG_W     = 4
) ();

   logic                   in_valid;
   logic                   in_ready;
   logic [2*NUM_PAIRS-1:0] din;
   pair_op_e               op;
   logic                   inv;
   logic [TAG_W-1:0]       tag_in;
   logic                   out_valid;
   logic                   out_ready;
   logic                   result;
   logic [TAG_W-1:0]       tag_out;
   logic                   busy;

   modport master (
      output in_valid, din, op, inv, tag_in, out_ready,
      input  in_ready, out_valid, result, tag_out, busy
   );

   modport slave (
      input  in_valid, din, op, inv, tag_in, out_ready,
      output in_ready, out_valid, result, tag_out, busy
   );

endinterface

// File: rtl/pair_tree_eval_pipe_stage.sv
// One reduction slice: XORs groups of 2**LEVELS bits into a register with
// valid/load handling. Payload MSB carries inv until the final slice folds it in.
module pair_tree_stage #(
   parameter int  IN_W   = 2,
   parameter int  LEVELS = 1,
   parameter int  TAG_W  = 4,
   parameter bit  FINAL  = 1'b0,
   localparam int OUT_W  = IN_W >> LEVELS,
   localparam int PW_OUT = FINAL ? 1 : OUT_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              up_valid,
   input  logic [IN_W:0]     up_pay,
   input  logic [TAG_W-1:0]  up_tag,
   output logic              valid,
   output logic [PW_OUT-1:0] pay,
   output logic [TAG_W-1:0]  tag
);

   localparam int GRP = 1 << LEVELS;

   logic [OUT_W-1:0]  red;
   logic [PW_OUT-1:0] nxt;

   always_comb begin
      red = '0;
      for (int j = 0; j < OUT_W; j++) begin
         red[j] = ^up_pay[j*GRP +: GRP];
      end
   end

   if (FINAL) begin : g_final
      assign nxt = red ^ up_pay[IN_W];
   end else begin : g_mid
      assign nxt = {up_pay[IN_W], red};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= up_valid;
      end
   end

   // Data only moves with a real transaction; a held stage keeps its contents.
   always_ff @(posedge clk) begin
      if (load && up_valid) begin
         pay <= nxt;
         tag <= up_tag;
      end
   end

endmodule

// File: rtl/pair_tree_eval_pipe.sv
// Pipelined pair-term evaluator: per-pair function, balanced XOR tree with a
// register every LVL_PER_STG levels, bubble-collapsing valid/ready flow.
module pair_tree_eval_pipe
   import pair_tree_pkg::*;
#(
   parameter int NUM_PAIRS   = 8,
   parameter int LVL_PER_STG = 1,
   parameter int TAG_W       = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   pair_tree_eval_pipe_if.slave bus
);

   localparam int S    = stage_count(NUM_PAIRS, LVL_PER_STG);
   localparam int LOG2 = $clog2(NUM_PAIRS);

   logic [S-1:0]         vld;
   logic [S-1:0]         load;
   logic [TAG_W-1:0]     tag_s [S];
   logic [NUM_PAIRS-1:0] terms;
   logic [NUM_PAIRS:0]   pay0;
   logic [TAG_W-1:0]     tag0;
   logic                 vld0;
   logic                 last_pay;

   // A stage may load whenever some stage at or below it is empty, or the output drains.
   always_comb begin
      logic all_full;
      load     = '0;
      all_full = 1'b1;
      for (int k = S - 1; k >= 0; k--) begin
         all_full = all_full & vld[k];
         load[k]  = bus.out_ready | ~all_full;
      end
   end

   always_comb begin
      terms = '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         terms[i] = pair_term(bus.op, bus.din[2*i+1], bus.din[2*i]);
      end
   end

   // Stage 0: capture pair terms, inv and tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0 <= 1'b0;
      end else if (load[0]) begin
         vld0 <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (load[0] && bus.in_valid) begin
         pay0 <= {bus.inv, terms};
         tag0 <= bus.tag_in;
      end
   end

   assign vld[0]   = vld0;
   assign tag_s[0] = tag0;

   // Stages 1..S-1: each folds up to LVL_PER_STG tree levels.
   for (genvar k = 1; k < S; k++) begin : g_stg
      localparam int  DONE   = (k - 1) * LVL_PER_STG;
      localparam int  IN_W   = NUM_PAIRS >> DONE;
      localparam int  LEVELS = (LOG2 - DONE < LVL_PER_STG) ? (LOG2 - DONE) : LVL_PER_STG;
      localparam bit  FINAL  = (k == S - 1);
      localparam int  PW_OUT = FINAL ? 1 : (IN_W >> LEVELS) + 1;

      logic [IN_W:0]     up_pay;
      logic [PW_OUT-1:0] pay;

      if (k == 1) begin : g_first
         assign up_pay = pay0;
      end else begin : g_next
         assign up_pay = g_stg[k-1].pay;
      end

      pair_tree_stage #(
         .IN_W   (IN_W),
         .LEVELS (LEVELS),
         .TAG_W  (TAG_W),
         .FINAL  (FINAL)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load[k]),
         .up_valid (vld[k-1]),
         .up_pay   (up_pay),
         .up_tag   (tag_s[k-1]),
         .valid    (vld[k]),
         .pay      (pay),
         .tag      (tag_s[k])
      );
   end

   assign last_pay = g_stg[S-1].pay[0];

   // Outputs read as zero whenever the output slot is empty, including after reset.
   assign bus.in_ready  = load[0];
   assign bus.out_valid = vld[S-1];
   assign bus.result    = vld[S-1] & last_pay;
   assign bus.tag_out   = vld[S-1] ? tag_s[S-1] : '0;
   assign bus.busy      = |vld;

endmodule

// File: doc/pair_tree_eval_pipe.md
Name: pair_tree_eval_pipe

Overview:
- Parametrised, pipelined successor to the fixed 16-input pair-term logic blocks in this codebase.
- Each input pair (a = din[2i+1], b = din[2i]) reduces to one pair term through a per-transaction selectable function.
- All pair terms are XOR-reduced through a balanced tree, with pipeline registers inserted every LVL_PER_STG tree levels.
- Valid/ready handshake on both sides with bubble-collapsing backpressure. A sideband tag travels alongside each result.

Parameters:
- NUM_PAIRS, 8, number of input pairs; power of two, >= 2. Data width = 2*NUM_PAIRS.
- LVL_PER_STG, 1, tree levels between pipeline registers; 1..log2(NUM_PAIRS).
- TAG_W, 4, width of the sideband tag carried with each transaction.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- din  in  2*NUM_PAIRS  operand bits.
- op  in  2  pair function: 0 ANDN (a&~b), 1 ORN (a|~b), 2 XOR, 3 XNOR.
- inv  in  1  invert final result.
- tag_in  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  1  XOR of all pair terms, XOR inv.
- tag_out  out  TAG_W  tag of the transaction in the output slot.
- busy  out  1  any pipeline stage valid.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: every stage valid bit clears immediately on rst_n low. out_valid=0, busy=0, result=0, tag_out=0. in_ready=1 once out of reset.
- Stage 0 register: captures the pair terms (NUM_PAIRS bits), inv and tag_in on an accepted input (in_valid & in_ready). op is consumed combinationally before stage 0 and is not stored.
- Stages 1..S-1: each reduces LVL_PER_STG tree levels of XOR.
  - S = 1 + ceil(log2(NUM_PAIRS)/LVL_PER_STG).
  - The final stage register holds the 1-bit reduction XOR inv, plus the tag.
- Latency: with no stall, a result appears S cycles after acceptance. Defaults give S=4.
- Throughput: one transaction per cycle when out_ready is held high.
- Stall rule, evaluated combinationally from output to input: stage k loads when !valid[k] or (stage k+1 loads). The last stage loads when !out_valid or out_ready.
- in_ready = stage-0 load condition.
- Bubbles collapse: an upstream transaction advances into an empty downstream slot even while the output is stalled.
- Stage hold: a stage whose valid is set and which does not load keeps its data bit-for-bit.
- Valid propagation: when a stage loads with an invalid upstream, its valid clears.
- out_valid is held until out_ready. result and tag_out are stable while out_valid & !out_ready.
- Simultaneous events: output handshake and input acceptance in the same cycle are legal with a full pipe. The pipe shifts by one and no transaction is lost or duplicated.
- Order: results leave strictly in acceptance order, each paired with its own tag.
- Reset mid-operation: all in-flight transactions are discarded. No output follows reset until a new input is accepted.
- busy = OR of all stage valid bits.
- Unused-input rule: din, op, inv and tag_in are ignored while in_valid=0.

Decomposition:
- Shared package pair_tree_pkg holds:
  - op encoding enum pair_op_e (ANDN, ORN, XOR, XNOR);
  - function pair_term(op, a, b);
  - localparam function for the stage count S, derived from NUM_PAIRS and LVL_PER_STG.
- One sub-module is natural: pair_tree_stage. It is a parametrised register slice with an input width, reduction level count, and valid/load logic, instantiated S-1 times by a generate loop.

Test Plan:
- Reset then single transaction: NUM_PAIRS=8, op=XOR, din=16'h0001, inv=0, tag=3 -> out_valid rises exactly 4 cycles after acceptance, result=1, tag_out=3.
- Pair functions: op=ANDN, din=16'hAAAA -> result=0 (8 ones XORed). op=ANDN, din=16'h0002 -> result=1. op=ORN, din=16'h0000, inv=1 -> result=1.
- Backpressure: stream 6 transactions with tags 0..5 back-to-back and out_ready=0 -> in_ready falls after 4 accepts. Release out_ready -> tags 0..5 emerge in order, one per cycle, with no loss or duplication; result and tag_out are stable while stalled.
- Bubble collapse: accept tag 1, idle 2 cycles, accept tag 2, with out_ready=0 until both are in the pipe -> both are held. Release -> tag 1 then tag 2 on consecutive cycles.
- Reset mid-operation: 3 transactions in flight, rst_n pulsed low asynchronously between clock edges -> out_valid and busy drop immediately, no stale output appears after reset, and the next accepted input gives the correct result after S cycles.
- Parameter sweep: NUM_PAIRS=16, LVL_PER_STG=2 -> S=3, 32-bit random din checked against the reference model over 1000 transactions with random out_ready.
